count_seq_checker: RTL and testbench
====================================

COUNT_SEQ_CHECKER -- requirements
Module: count_seq_checker

Interface
REQ-001 Parameter: WRAP_W, default 8, width of the wrap counter output.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 q  input  2  count value from the upstream 2-bit up counter, sampled every clk.
REQ-005 en  input  1  checking enable; 0 forces IDLE.
REQ-006 clr_err  input  1  clears error record; in FAULT also returns FSM to IDLE.
REQ-007 locked  output  1  high only while FSM is in TRACK.
REQ-008 err  output  1  sticky error flag.
REQ-009 err_pulse  output  1  one-cycle strobe per detected mismatch.
REQ-010 err_exp  output  2  expected value at first error since last clear.
REQ-011 err_got  output  2  sampled value at first error since last clear.
REQ-012 wraps  output  WRAP_W  count of 3->0 transitions seen in TRACK, saturating.

Function
REQ-013 The FSM SHALL have three states: IDLE, TRACK, FAULT; all outputs are registered.
REQ-014 IDLE: en=1 -> capture q into prev, go to TRACK next cycle; en=0 -> stay.
REQ-015 TRACK: expected = (prev+1) mod 4; q==expected -> prev<=q, stay TRACK.
REQ-016 TRACK, q==expected with prev=3, q=0 -> wraps increments by 1, holding at 2^WRAP_W-1.
REQ-017 TRACK, q!=expected (hold counts as mismatch) -> FAULT, err<=1, err_pulse<=1 for exactly one cycle.
REQ-018 err_exp/err_got SHALL load only when err is 0 before the mismatch; later mismatches keep first record.
REQ-019 FAULT: no checking, no wrap counting; prev<=q every cycle; locked=0.
REQ-020 FAULT with clr_err=1 -> IDLE next cycle; err, err_exp, err_got cleared.
REQ-021 clr_err in IDLE or TRACK SHALL clear err, err_exp, err_got without a state change.
REQ-022 Mismatch and clr_err in the same TRACK cycle: mismatch wins (err=1, record loaded, FAULT).
REQ-023 en=0 in any state -> IDLE next cycle; err, err_exp, err_got, wraps retained.
REQ-024 en=0 and clr_err=1 same cycle -> IDLE and error record cleared.
REQ-025 Latency: locked, err, err_pulse, wraps SHALL reflect a sample on the clock edge that samples it (visible next cycle).

Reset
REQ-026 reset=1 SHALL force IDLE, prev=0, locked=0, err=0, err_pulse=0, err_exp=0, err_got=0, wraps=0, overriding all other inputs.
REQ-027 reset mid-TRACK or mid-FAULT SHALL abandon state with no err_pulse generated in that cycle.

Structure
REQ-028 A shared package SHALL hold the state enumeration (IDLE, TRACK, FAULT) and the 2-bit count width constant.
REQ-029 The saturating wrap counter SHALL be a sub-module named sat_counter (width parameter, synchronous reset, inc input).
REQ-030 Next-expected computation SHALL be 2-bit modulo-4 addition; no wider arithmetic on q.

Verification
REQ-031 reset, then en=1, q=0,1,2,3,0,1 -> locked=1 from 2nd cycle, err=0, wraps=1.
REQ-032 TRACK with prev=1, q=3 -> err_pulse one cycle, err=1, err_exp=2, err_got=3, locked=0, FSM FAULT.
REQ-033 Second mismatch after clr_err absent (en toggled, retrack, q stuck) -> err_exp/err_got unchanged from first error.
REQ-034 Mismatch and clr_err same cycle -> err=1, record loaded; clr_err one cycle later in FAULT -> err=0, IDLE.
REQ-035 WRAP_W=2, 5 clean wraps -> wraps saturates at 3.
REQ-036 reset asserted during FAULT with err=1 -> all outputs 0 next cycle, IDLE.

Source files
------------

// File: rtl/count_seq_checker_pkg.sv
// Shared types for the count sequence checker: FSM states and count width.
// Also provides the modulo-4 successor used to predict the next count.
package count_seq_checker_pkg;

    localparam int CNT_W = 2;

    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        FAULT = 2'd2
    } state_e;

    // Stays at CNT_W bits so 3 rolls over to 0.
    function automatic cnt_t next_cnt(input cnt_t v);
        return v + cnt_t'(1);
    endfunction

endpackage

// File: rtl/count_seq_checker_sat_counter.sv
// Saturating up counter: counts inc pulses, holds at all-ones.
// Ports: clk, reset (sync, active-high), inc, cnt[WIDTH-1:0].
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt
);

    logic [WIDTH-1:0] cnt_d;
    logic [WIDTH-1:0] cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != {WIDTH{1'b1}})) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/count_seq_checker.sv
// Checks that a 2-bit up counter steps 0,1,2,3,0,... every clock.
// Ports: clk, reset (sync, active-high), q (sampled count), en, clr_err;
// outputs locked, err, err_pulse, err_exp, err_got, wraps (all registered).
module count_seq_checker
    import count_seq_checker_pkg::*;
#(
    parameter int WRAP_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        q,
    input  logic              en,
    input  logic              clr_err,
    output logic              locked,
    output logic              err,
    output logic              err_pulse,
    output logic [1:0]        err_exp,
    output logic [1:0]        err_got,
    output logic [WRAP_W-1:0] wraps
);

    state_e state_d;
    state_e state_q;
    cnt_t   prev_d;
    cnt_t   prev_q;
    logic   locked_d;
    logic   locked_q;
    logic   err_d;
    logic   err_q;
    logic   pulse_d;
    logic   pulse_q;
    cnt_t   exp_d;
    cnt_t   exp_q;
    cnt_t   got_d;
    cnt_t   got_q;

    cnt_t   exp_cnt;
    logic   hit;
    logic   clr_rec;
    logic   wrap_inc;

    assign exp_cnt = next_cnt(prev_q);
    assign hit     = (q == exp_cnt);

    always_comb begin
        state_d  = state_q;
        prev_d   = prev_q;
        err_d    = err_q;
        pulse_d  = 1'b0;
        exp_d    = exp_q;
        got_d    = got_q;
        clr_rec  = 1'b0;
        wrap_inc = 1'b0;

        if (!en) begin
            state_d = IDLE;
            clr_rec = clr_err;
        end else begin
            unique case (state_q)
                IDLE: begin
                    prev_d  = q;
                    state_d = TRACK;
                    clr_rec = clr_err;
                end
                TRACK: begin
                    prev_d = q;
                    if (hit) begin
                        wrap_inc = (prev_q == cnt_t'(3));
                        clr_rec  = clr_err;
                    end else begin
                        // A mismatch outranks a same-cycle clear.
                        state_d = FAULT;
                        err_d   = 1'b1;
                        pulse_d = 1'b1;
                        if (!err_q) begin
                            exp_d = exp_cnt;
                            got_d = q;
                        end
                    end
                end
                FAULT: begin
                    prev_d = q;
                    if (clr_err) begin
                        clr_rec = 1'b1;
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        if (clr_rec) begin
            err_d = 1'b0;
            exp_d = '0;
            got_d = '0;
        end

        locked_d = (state_d == TRACK);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            prev_q   <= '0;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
            pulse_q  <= 1'b0;
            exp_q    <= '0;
            got_q    <= '0;
        end else begin
            state_q  <= state_d;
            prev_q   <= prev_d;
            locked_q <= locked_d;
            err_q    <= err_d;
            pulse_q  <= pulse_d;
            exp_q    <= exp_d;
            got_q    <= got_d;
        end
    end

    sat_counter #(
        .WIDTH (WRAP_W)
    ) u_wraps (
        .clk   (clk),
        .reset (reset),
        .inc   (wrap_inc),
        .cnt   (wraps)
    );

    assign locked    = locked_q;
    assign err       = err_q;
    assign err_pulse = pulse_q;
    assign err_exp   = exp_q;
    assign err_got   = got_q;

endmodule

// File: tb/tb_count_seq_checker.sv
// Directed bench for count_seq_checker with a behavioural reference model.
// Two instances (WRAP_W=8 and WRAP_W=2) share stimulus.
module tb_count_seq_checker;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic       clr_err;
    logic [1:0] q;

    logic       locked, err, err_pulse;
    logic [1:0] err_exp, err_got;
    logic [7:0] wraps;

    logic       locked2, err2, err_pulse2;
    logic [1:0] err_exp2, err_got2;
    logic [1:0] wraps2;

    int checks = 0;
    int errors = 0;
    bit run    = 1'b0;

    // Model: mode 0 idle, 1 tracking, 2 faulted.
    int m_mode, m_prev, m_err, m_pulse, m_exp, m_got, m_wcnt;

    always #5 clk = ~clk;

    count_seq_checker #(.WRAP_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .q         (q),
        .en        (en),
        .clr_err   (clr_err),
        .locked    (locked),
        .err       (err),
        .err_pulse (err_pulse),
        .err_exp   (err_exp),
        .err_got   (err_got),
        .wraps     (wraps)
    );

    count_seq_checker #(.WRAP_W(2)) dut2 (
        .clk       (clk),
        .reset     (reset),
        .q         (q),
        .en        (en),
        .clr_err   (clr_err),
        .locked    (locked2),
        .err       (err2),
        .err_pulse (err_pulse2),
        .err_exp   (err_exp2),
        .err_got   (err_got2),
        .wraps     (wraps2)
    );

    function automatic int sat(input int v, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic clear_rec();
        m_err = 0;
        m_exp = 0;
        m_got = 0;
    endtask

    // Applies the rules to the inputs sampled at this edge.
    task automatic model_step();
        int qi;
        qi = int'(q);
        m_pulse = 0;
        if (reset) begin
            m_mode = 0; m_prev = 0; m_wcnt = 0;
            clear_rec();
        end else if (!en) begin
            m_mode = 0;
            if (clr_err) clear_rec();
        end else if (m_mode == 0) begin
            m_prev = qi;
            m_mode = 1;
            if (clr_err) clear_rec();
        end else if (m_mode == 1) begin
            if (qi == (m_prev + 1) % 4) begin
                if (qi == 0) m_wcnt++;
                if (clr_err) clear_rec();
            end else begin
                m_pulse = 1;
                if (m_err == 0) begin
                    m_exp = (m_prev + 1) % 4;
                    m_got = qi;
                end
                m_err  = 1;
                m_mode = 2;
            end
            m_prev = qi;
        end else begin
            m_prev = qi;
            if (clr_err) begin
                clear_rec();
                m_mode = 0;
            end
        end
    endtask

    task automatic step(input bit e, input bit c,
                        input int qv, input bit r);
        logic [31:0] qw;
        qw = qv;
        @(negedge clk);
        en      = e;
        clr_err = c;
        q       = qw[1:0];
        reset   = r;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic lit(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    always @(negedge clk) begin
        if (run) begin
            checks++;
            if (locked !== (m_mode == 1) || err !== m_err[0] ||
                err_pulse !== m_pulse[0] ||
                int'(err_exp) != m_exp || int'(err_got) != m_got ||
                int'(wraps) != sat(m_wcnt, 8)) begin
                errors++;
                $display("FAIL w8 @%0t: got l%b e%b p%b x%0d g%0d w%0d expected l%0d e%0d p%0d x%0d g%0d w%0d",
                         $time, locked, err, err_pulse, err_exp, err_got, wraps,
                         (m_mode == 1), m_err, m_pulse, m_exp, m_got, sat(m_wcnt, 8));
            end
            checks++;
            if (locked2 !== (m_mode == 1) || err2 !== m_err[0] ||
                err_pulse2 !== m_pulse[0] ||
                int'(err_exp2) != m_exp || int'(err_got2) != m_got ||
                int'(wraps2) != sat(m_wcnt, 2)) begin
                errors++;
                $display("FAIL w2 @%0t: got l%b e%b p%b x%0d g%0d w%0d expected w%0d",
                         $time, locked2, err2, err_pulse2, err_exp2, err_got2,
                         wraps2, sat(m_wcnt, 2));
            end
        end
    end

    initial begin
        reset = 1'b1; en = 1'b0; clr_err = 1'b0; q = 2'd0;
        step(1, 1, 3, 1);
        step(1, 0, 2, 1);
        run = 1'b1;
        lit("rst_locked", int'(locked), 0);
        lit("rst_err", int'(err), 0);
        lit("rst_wraps", int'(wraps), 0);

        // Clean run 0,1,2,3,0,1 -> one wrap.
        step(1, 0, 0, 0);
        lit("lock_2nd", int'(locked), 1);
        step(1, 0, 1, 0);
        step(1, 0, 2, 0);
        step(1, 0, 3, 0);
        step(1, 0, 0, 0);
        step(1, 0, 1, 0);
        lit("clean_locked", int'(locked), 1);
        lit("clean_err", int'(err), 0);
        lit("clean_wraps", int'(wraps), 1);

        // prev=1, q=3 -> expected 2.
        step(1, 0, 3, 0);
        lit("mm_pulse", int'(err_pulse), 1);
        lit("mm_err", int'(err), 1);
        lit("mm_exp", int'(err_exp), 2);
        lit("mm_got", int'(err_got), 3);
        lit("mm_locked", int'(locked), 0);
        step(1, 0, 0, 0);
        lit("pulse_once", int'(err_pulse), 0);

        // en toggle, retrack, stuck count: first record kept.
        step(0, 0, 0, 0);
        lit("en0_keep_err", int'(err), 1);
        step(1, 0, 0, 0);
        step(1, 0, 1, 0);
        step(1, 0, 1, 0);
        lit("mm2_pulse", int'(err_pulse), 1);
        lit("mm2_exp", int'(err_exp), 2);
        lit("mm2_got", int'(err_got), 3);

        // Clear from FAULT, then mismatch with clr in same cycle.
        step(1, 1, 1, 0);
        lit("fclr_err", int'(err), 0);
        lit("fclr_exp", int'(err_exp), 0);
        step(1, 0, 2, 0);
        step(1, 0, 3, 0);
        step(1, 1, 3, 0);
        lit("mmclr_err", int'(err), 1);
        lit("mmclr_exp", int'(err_exp), 0);
        lit("mmclr_got", int'(err_got), 3);
        step(1, 1, 3, 0);
        lit("clr_idle_err", int'(err), 0);
        lit("clr_idle_lock", int'(locked), 0);

        // Clear in TRACK, and en=0 with clear.
        step(1, 0, 0, 0);
        step(1, 0, 2, 0);
        step(0, 0, 2, 0);
        step(1, 0, 2, 0);
        step(1, 1, 3, 0);
        lit("tclr_err", int'(err), 0);
        lit("tclr_lock", int'(locked), 1);
        step(1, 0, 2, 0);
        lit("mm3_exp", int'(err_exp), 0);
        lit("mm3_got", int'(err_got), 2);
        step(0, 1, 2, 0);
        lit("en0clr_err", int'(err), 0);
        lit("en0clr_lock", int'(locked), 0);

        // Five clean wraps: narrow counter saturates.
        step(1, 0, 0, 0);
        for (int i = 1; i <= 20; i++) begin
            step(1, 0, i % 4, 0);
        end
        lit("sat_wraps2", int'(wraps2), 3);
        lit("wide_wraps", int'(wraps), 6);

        // Fault then reset.
        step(1, 0, 0, 0);
        lit("pre_rst_err", int'(err), 1);
        step(1, 0, 1, 1);
        lit("frst_err", int'(err), 0);
        lit("frst_pulse", int'(err_pulse), 0);
        lit("frst_wraps", int'(wraps), 0);
        lit("frst_got", int'(err_got), 0);
        step(0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
